// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared constants for the ALU datapath.
//   ADD_W    : default operand/result width of the adder/subtractor
//   MODE_ADD : mode bit value selecting A+B
//   MODE_SUB : mode bit value selecting A-B
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam int ADD_W = 16;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

endpackage : alu_pkg

// File: rtl/full_adder.sv
// -----------------------------------------------------------------------------
// full_adder
// One-bit full adder stage used to build the ripple-carry chain.
//   a, b : operand bits
//   cin  : carry in from the next less-significant stage
//   s    : sum bit
//   co   : carry out to the next more-significant stage
// -----------------------------------------------------------------------------
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic co
);

    logic p;

    // Propagate term is shared by the sum and the carry.
    assign p  = a ^ b;
    assign s  = p ^ cin;
    assign co = (a & b) | (cin & p);

endmodule : full_adder

// File: rtl/two_complement_16bit_adder.sv
// -----------------------------------------------------------------------------
// two_complement_16bit_adder
// Registered two's-complement adder/subtractor built from a ripple chain of
// full adders. Results appear one clock after the operands.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (clears S, cout, ovf)
//   A, B  : WIDTH-bit two's-complement operands
//   M     : mode, MODE_ADD (0) = A+B, MODE_SUB (1) = A-B
//   S     : registered WIDTH-bit result, wraps modulo 2^WIDTH
//   cout  : registered raw carry out of the MSB (1 = no borrow when subtracting)
//   ovf   : registered signed overflow
// -----------------------------------------------------------------------------
import alu_pkg::*;

module two_complement_16bit_adder #(
    parameter int WIDTH = ADD_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             M,
    output logic [WIDTH-1:0] S,
    output logic             cout,
    output logic             ovf
);

    logic [WIDTH-1:0] bx;
    logic [WIDTH-1:0] sum;
    logic [WIDTH:0]   c;
    logic             ovf_next;

    // Subtraction is A + ~B + 1: invert B and inject the mode bit as carry-in.
    assign bx   = B ^ {WIDTH{M == MODE_SUB}};
    assign c[0] = (M == MODE_SUB);

    for (genvar i = 0; i < WIDTH; i++) begin : g_stage
        full_adder u_fa (
            .a   (A[i]),
            .b   (bx[i]),
            .cin (c[i]),
            .s   (sum[i]),
            .co  (c[i+1])
        );
    end

    // Signed overflow: carry into the sign bit differs from carry out of it.
    assign ovf_next = c[WIDTH] ^ c[WIDTH-1];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            S    <= '0;
            cout <= 1'b0;
            ovf  <= 1'b0;
        end else begin
            S    <= sum;
            cout <= c[WIDTH];
            ovf  <= ovf_next;
        end
    end

endmodule : two_complement_16bit_adder

// File: tb/tb_two_complement_16bit_adder.sv
// -----------------------------------------------------------------------------
// tb_two_complement_16bit_adder
// Directed-vector bench for the registered 16-bit adder/subtractor. Inputs are
// driven on the falling edge; outputs are sampled 1 ns after the rising edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_two_complement_16bit_adder;

    logic        clk;
    logic        rst_n;
    logic [15:0] A;
    logic [15:0] B;
    logic        M;
    logic [15:0] S;
    logic        cout;
    logic        ovf;

    int n_checks = 0;
    int n_fail   = 0;

    two_complement_16bit_adder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .A     (A),
        .B     (B),
        .M     (M),
        .S     (S),
        .cout  (cout),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive a vector on the falling edge, then wait until just after the
    // next rising edge so the registered result is visible.
    task automatic apply_vec(input logic [15:0] a, input logic [15:0] b, input logic m);
        @(negedge clk);
        A = a;
        B = b;
        M = m;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        A = 16'h1234;
        B = 16'h0001;
        M = 1'b0;
        #1;
        n_checks++;
        if ({S, cout, ovf} !== {16'h0000, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_t0: got S=%h cout=%b ovf=%b, want S=0000 cout=0 ovf=0", S, cout, ovf);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if ({S, cout, ovf} !== {16'h0000, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL reset_hold[%0d]: got S=%h cout=%b ovf=%b, want S=0000 cout=0 ovf=0", i, S, cout, ovf);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if ({S, cout, ovf} !== {16'h1235, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_release: got S=%h cout=%b ovf=%b, want S=1235 cout=0 ovf=0", S, cout, ovf);
        end
    endtask

    task automatic test_add_sub();
        apply_vec(16'h0010, 16'h0004, 1'b0);
        n_checks++;
        if ({S, cout, ovf} !== {16'h0014, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL add_basic: got S=%h cout=%b ovf=%b, want S=0014 cout=0 ovf=0", S, cout, ovf);
        end
        apply_vec(16'h0010, 16'h0004, 1'b1);
        n_checks++;
        if ({S, cout, ovf} !== {16'h000C, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL sub_basic: got S=%h cout=%b ovf=%b, want S=000c cout=1 ovf=0", S, cout, ovf);
        end
        // Same add vector after a subtract must give the identical result.
        apply_vec(16'h0010, 16'h0004, 1'b0);
        n_checks++;
        if ({S, cout, ovf} !== {16'h0014, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL add_repeat: got S=%h cout=%b ovf=%b, want S=0014 cout=0 ovf=0", S, cout, ovf);
        end
    endtask

    task automatic test_borrow_zero();
        apply_vec(16'h0000, 16'h0001, 1'b1);
        n_checks++;
        if ({S, cout, ovf} !== {16'hFFFF, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL sub_borrow: got S=%h cout=%b ovf=%b, want S=ffff cout=0 ovf=0", S, cout, ovf);
        end
        apply_vec(16'h0005, 16'h0005, 1'b1);
        n_checks++;
        if ({S, cout, ovf} !== {16'h0000, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL sub_zero: got S=%h cout=%b ovf=%b, want S=0000 cout=1 ovf=0", S, cout, ovf);
        end
    endtask

    task automatic test_overflow();
        apply_vec(16'h7FFF, 16'h0001, 1'b0);
        n_checks++;
        if ({S, cout, ovf} !== {16'h8000, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL ovf_add_pos: got S=%h cout=%b ovf=%b, want S=8000 cout=0 ovf=1", S, cout, ovf);
        end
        apply_vec(16'h8000, 16'h0001, 1'b1);
        n_checks++;
        if ({S, cout, ovf} !== {16'h7FFF, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL ovf_sub_neg: got S=%h cout=%b ovf=%b, want S=7fff cout=1 ovf=1", S, cout, ovf);
        end
        apply_vec(16'hFFFF, 16'h0001, 1'b0);
        n_checks++;
        if ({S, cout, ovf} !== {16'h0000, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL wrap_carry: got S=%h cout=%b ovf=%b, want S=0000 cout=1 ovf=0", S, cout, ovf);
        end
    endtask

    // New vector every cycle; before the edge the previous result must still
    // be held, after the edge the new one must appear.
    task automatic test_back_to_back();
        logic [15:0] va   [5] = '{16'h1111, 16'h5000, 16'h0003, 16'hFFFE, 16'h8000};
        logic [15:0] vb   [5] = '{16'h2222, 16'h3000, 16'h0007, 16'h0003, 16'h8000};
        logic        vm   [5] = '{1'b0,     1'b0,     1'b1,     1'b0,     1'b0};
        logic [15:0] es   [5] = '{16'h3333, 16'h8000, 16'hFFFC, 16'h0001, 16'h0000};
        logic        ec   [5] = '{1'b0,     1'b0,     1'b0,     1'b1,     1'b1};
        logic        eo   [5] = '{1'b0,     1'b1,     1'b0,     1'b0,     1'b1};
        logic [17:0] prev;
        prev = {16'h0000, 1'b1, 1'b0}; // result left by test_overflow
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            A = va[i];
            B = vb[i];
            M = vm[i];
            #1;
            n_checks++;
            if ({S, cout, ovf} !== prev) begin
                n_fail++;
                $display("FAIL b2b_hold[%0d]: got S=%h cout=%b ovf=%b, want S=%h cout=%b ovf=%b",
                         i, S, cout, ovf, prev[17:2], prev[1], prev[0]);
            end
            @(posedge clk);
            #1;
            n_checks++;
            if ({S, cout, ovf} !== {es[i], ec[i], eo[i]}) begin
                n_fail++;
                $display("FAIL b2b_result[%0d]: got S=%h cout=%b ovf=%b, want S=%h cout=%b ovf=%b",
                         i, S, cout, ovf, es[i], ec[i], eo[i]);
            end
            prev = {es[i], ec[i], eo[i]};
        end
    endtask

    task automatic test_async_reset();
        apply_vec(16'h0100, 16'h0023, 1'b0);
        n_checks++;
        if ({S, cout, ovf} !== {16'h0123, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL pre_async: got S=%h cout=%b ovf=%b, want S=0123 cout=0 ovf=0", S, cout, ovf);
        end
        // Assert reset between edges: outputs must clear without a clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({S, cout, ovf} !== {16'h0000, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL async_clear: got S=%h cout=%b ovf=%b, want S=0000 cout=0 ovf=0", S, cout, ovf);
        end
        @(negedge clk);
        A = 16'h7FFF;
        B = 16'h7FFF;
        M = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if ({S, cout, ovf} !== {16'h0000, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL async_hold: got S=%h cout=%b ovf=%b, want S=0000 cout=0 ovf=0", S, cout, ovf);
        end
        @(negedge clk);
        rst_n = 1'b1;
        A = 16'h0003;
        B = 16'h0005;
        M = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if ({S, cout, ovf} !== {16'hFFFE, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL async_release: got S=%h cout=%b ovf=%b, want S=fffe cout=0 ovf=0", S, cout, ovf);
        end
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_borrow_zero();
        test_overflow();
        test_back_to_back();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_two_complement_16bit_adder
